// File: rtl/cpu_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : cpu_sram_ctrl
// Description: CPU byte-bus responder for a 16-bit async SRAM, wait-stated.
// Revision   : 1.0 - initial release
// ============================================================================
module cpu_sram_ctrl #(
  parameter int SRAM_AW = 18,  // must be >= 15
  parameter int RD_WAIT = 2,   // >= 1
  parameter int WR_WAIT = 2    // >= 1
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  input  logic [15:0]        i_cpu_addr,
  input  logic               i_cpu_cs,
  input  logic               i_cpu_rd_req,
  input  logic               i_cpu_wr_en,
  input  logic [7:0]         i_cpu_wr_data,
  output logic [7:0]         o_cpu_rd_data,
  output logic               o_cpu_ready,
  output logic [SRAM_AW-1:0] o_sram_addr,
  input  logic [15:0]        i_sram_dq_in,
  output logic [15:0]        o_sram_dq_out,
  output logic               o_sram_dq_oe,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_ub_n,
  output logic               o_sram_lb_n
);

  localparam int C_MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int C_CW       = (C_MAX_WAIT > 1) ? $clog2(C_MAX_WAIT) : 1;
  localparam logic [C_CW-1:0] C_RD_CNT = C_CW'(RD_WAIT - 1);
  localparam logic [C_CW-1:0] C_WR_CNT = C_CW'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4
  } state_t;

  state_t          r_state, w_state;
  logic [C_CW-1:0] r_cnt, w_cnt;
  logic            r_hi, w_hi;
  logic [14:0]     r_addr, w_addr;
  logic [15:0]     r_dq_out, w_dq_out;
  logic            r_dq_oe, w_dq_oe;
  logic            r_ce_n, w_ce_n;
  logic            r_oe_n, w_oe_n;
  logic            r_we_n, w_we_n;
  logic            r_ub_n, w_ub_n;
  logic            r_lb_n, w_lb_n;
  logic            r_ready, w_ready;
  logic [7:0]      r_rd_data, w_rd_data;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_hi      = r_hi;
    w_addr    = r_addr;
    w_dq_out  = r_dq_out;
    w_dq_oe   = r_dq_oe;
    w_ce_n    = r_ce_n;
    w_oe_n    = r_oe_n;
    w_we_n    = r_we_n;
    w_ub_n    = r_ub_n;
    w_lb_n    = r_lb_n;
    w_ready   = r_ready;
    w_rd_data = r_rd_data;
    case (r_state)
      S_IDLE: begin
        // Write takes priority over a simultaneous read request.
        if (i_cpu_cs && i_cpu_wr_en) begin
          w_addr   = i_cpu_addr[15:1];
          w_hi     = i_cpu_addr[0];
          w_dq_out = {i_cpu_wr_data, i_cpu_wr_data};
          w_dq_oe  = 1'b1;
          w_ce_n   = 1'b0;
          w_ub_n   = ~i_cpu_addr[0];
          w_lb_n   = i_cpu_addr[0];
          w_ready  = 1'b0;
          w_state  = S_WR_SETUP;
        end else if (i_cpu_cs && i_cpu_rd_req) begin
          w_addr   = i_cpu_addr[15:1];
          w_hi     = i_cpu_addr[0];
          w_ce_n   = 1'b0;
          w_oe_n   = 1'b0;
          w_ub_n   = ~i_cpu_addr[0];
          w_lb_n   = i_cpu_addr[0];
          w_ready  = 1'b0;
          w_cnt    = C_RD_CNT;
          w_state  = S_RD;
        end
      end
      S_RD: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - C_CW'(1);
        end else begin
          w_rd_data = r_hi ? i_sram_dq_in[15:8] : i_sram_dq_in[7:0];
          w_ce_n    = 1'b1;
          w_oe_n    = 1'b1;
          w_ub_n    = 1'b1;
          w_lb_n    = 1'b1;
          w_ready   = 1'b1;
          w_state   = S_IDLE;
        end
      end
      S_WR_SETUP: begin
        w_we_n  = 1'b0;
        w_cnt   = C_WR_CNT;
        w_state = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - C_CW'(1);
        end else begin
          w_we_n  = 1'b1;
          w_state = S_WR_HOLD;
        end
      end
      S_WR_HOLD: begin
        // Address and data stay driven one more cycle after we_n rises.
        w_ce_n  = 1'b1;
        w_ub_n  = 1'b1;
        w_lb_n  = 1'b1;
        w_dq_oe = 1'b0;
        w_ready = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= 1'b0;
      r_addr    <= '0;
      r_dq_out  <= '0;
      r_dq_oe   <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_ub_n    <= 1'b1;
      r_lb_n    <= 1'b1;
      r_ready   <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_hi      <= w_hi;
      r_addr    <= w_addr;
      r_dq_out  <= w_dq_out;
      r_dq_oe   <= w_dq_oe;
      r_ce_n    <= w_ce_n;
      r_oe_n    <= w_oe_n;
      r_we_n    <= w_we_n;
      r_ub_n    <= w_ub_n;
      r_lb_n    <= w_lb_n;
      r_ready   <= w_ready;
      r_rd_data <= w_rd_data;
    end
  end

  assign o_cpu_rd_data = r_rd_data;
  assign o_cpu_ready   = r_ready;
  assign o_sram_addr   = {{(SRAM_AW-15){1'b0}}, r_addr};
  assign o_sram_dq_out = r_dq_out;
  assign o_sram_dq_oe  = r_dq_oe;
  assign o_sram_ce_n   = r_ce_n;
  assign o_sram_oe_n   = r_oe_n;
  assign o_sram_we_n   = r_we_n;
  assign o_sram_ub_n   = r_ub_n;
  assign o_sram_lb_n   = r_lb_n;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_cpu_sram_ctrl
// Description: Scoreboard bench for cpu_sram_ctrl with a behavioural SRAM.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_cpu_sram_ctrl;

  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         rlow;
    int         welow;
    int         oelow;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_cpu_addr = '0;
  logic        i_cpu_cs = 1'b0;
  logic        i_cpu_rd_req = 1'b0;
  logic        i_cpu_wr_en = 1'b0;
  logic [7:0]  i_cpu_wr_data = '0;
  logic [7:0]  o_cpu_rd_data;
  logic        o_cpu_ready;
  logic [17:0] o_sram_addr;
  logic [15:0] w_sram_dq_in;
  logic [15:0] o_sram_dq_out;
  logic        o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n;

  logic [15:0] mem [0:32767];
  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  cpu_sram_ctrl #(.SRAM_AW(18), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .i_sys_clk    (clk),
    .i_reset      (i_reset),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_cs     (i_cpu_cs),
    .i_cpu_rd_req (i_cpu_rd_req),
    .i_cpu_wr_en  (i_cpu_wr_en),
    .i_cpu_wr_data(i_cpu_wr_data),
    .o_cpu_rd_data(o_cpu_rd_data),
    .o_cpu_ready  (o_cpu_ready),
    .o_sram_addr  (o_sram_addr),
    .i_sram_dq_in (w_sram_dq_in),
    .o_sram_dq_out(o_sram_dq_out),
    .o_sram_dq_oe (o_sram_dq_oe),
    .o_sram_ce_n  (o_sram_ce_n),
    .o_sram_oe_n  (o_sram_oe_n),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_ub_n  (o_sram_ub_n),
    .o_sram_lb_n  (o_sram_lb_n)
  );

  // Behavioural async SRAM: combinational read, byte-lane write while we_n low.
  assign w_sram_dq_in = mem[o_sram_addr[14:0]];
  always @(posedge clk) begin
    if (!o_sram_ce_n && !o_sram_we_n && o_sram_dq_oe) begin
      if (!o_sram_lb_n) mem[o_sram_addr[14:0]][7:0]  <= o_sram_dq_out[7:0];
      if (!o_sram_ub_n) mem[o_sram_addr[14:0]][15:8] <= o_sram_dq_out[15:8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: measures each ready-low window and pops the expected response.
  int   m_rl = 0, m_wl = 0, m_ol = 0;
  logic m_ab = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_oe_overlap", {31'd0, (!o_sram_we_n && !o_sram_oe_n)}, 32'd0);
      if (!o_cpu_ready) begin
        m_rl++;
        if (!o_sram_we_n) m_wl++;
        if (!o_sram_oe_n) m_ol++;
        if (i_reset) m_ab = 1'b1;
      end else begin
        if (m_rl > 0) begin
          if (q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("abort_seen", {31'd0, m_ab}, {31'd0, (e.kind == K_ABORT)});
            if (e.kind != K_ABORT) begin
              chk("ready_low_cycles", m_rl, e.rlow);
              chk("we_low_cycles", m_wl, e.welow);
              chk("oe_low_cycles", m_ol, e.oelow);
              if (e.kind == K_READ) chk("rd_data", {24'd0, o_cpu_rd_data}, {24'd0, e.data});
            end
          end
        end
        m_rl = 0; m_wl = 0; m_ol = 0; m_ab = 1'b0;
        chk("idle_strobes", {28'd0, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_dq_oe},
            32'b1110);
      end
    end
  end

  task automatic push(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind; e.data = d;
    e.rlow  = (kind == K_READ) ? 2 : 4;
    e.welow = (kind == K_READ) ? 0 : 2;
    e.oelow = (kind == K_READ) ? 2 : 0;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the request edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] d,
                       input logic rd, input logic wr, input logic cs);
    i_cpu_addr = a; i_cpu_wr_data = d;
    i_cpu_rd_req = rd; i_cpu_wr_en = wr; i_cpu_cs = cs;
    @(posedge clk); #1;
    i_cpu_rd_req = 1'b0; i_cpu_wr_en = 1'b0; i_cpu_cs = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_cpu_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_cpu_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[15'h091A] = 16'hAB12;
    mem[15'h0020] = 16'h7700;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, o_cpu_ready}, 32'd1);
    chk("rst_rd_data", {24'd0, o_cpu_rd_data}, 32'd0);
    chk("rst_addr", {14'd0, o_sram_addr}, 32'd0);
    chk("rst_dq_out", {16'd0, o_sram_dq_out}, 32'd0);
    chk("rst_strobes", {26'd0, o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n,
                        o_sram_ub_n, o_sram_lb_n}, 32'b011111);
    i_reset = 1'b0;
    mon_en  = 1'b1;
    @(posedge clk); #1;

    // Read high byte of word 0x091A.
    push(K_READ, 8'hAB);
    issue(16'h1235, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("rd_addr", {14'd0, o_sram_addr}, 32'h091A);
    chk("rd_lanes", {30'd0, o_sram_ub_n, o_sram_lb_n}, 32'b01);
    chk("rd_oe_n", {31'd0, o_sram_oe_n}, 32'd0);
    chk("rd_ready", {31'd0, o_cpu_ready}, 32'd0);
    wait_ready();

    // Low byte of the same word.
    push(K_READ, 8'h12);
    issue(16'h1234, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("rd_lo_lanes", {30'd0, o_sram_ub_n, o_sram_lb_n}, 32'b10);
    wait_ready();

    // Write 0x55 to low byte of word 0x20.
    push(K_WRITE, 8'h00);
    issue(16'h0040, 8'h55, 1'b0, 1'b1, 1'b1);
    chk("wr_dq_out", {16'd0, o_sram_dq_out}, 32'h5555);
    chk("wr_lanes", {30'd0, o_sram_ub_n, o_sram_lb_n}, 32'b10);
    chk("wr_setup", {29'd0, o_sram_dq_oe, o_sram_we_n, o_sram_ce_n}, 32'b110);
    wait_ready();
    chk("mem_0x20", {16'd0, mem[15'h0020]}, 32'h7755);

    // cs=0 request is ignored; rd_data holds last read.
    issue(16'h1235, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      chk("nocs_ready", {31'd0, o_cpu_ready}, 32'd1);
      @(posedge clk); #1;
    end
    chk("rd_data_hold", {24'd0, o_cpu_rd_data}, 32'h12);

    // Back-to-back chain: write high byte, read it back, read low byte.
    push(K_WRITE, 8'h00);
    issue(16'h0041, 8'hC3, 1'b0, 1'b1, 1'b1);
    wait_ready();
    push(K_READ, 8'hC3);
    issue(16'h0041, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_ready();
    push(K_READ, 8'h55);
    issue(16'h0040, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_ready();

    // Simultaneous read and write: write wins.
    push(K_WRITE, 8'h00);
    issue(16'h0100, 8'h9A, 1'b1, 1'b1, 1'b1);
    chk("both_oe_n", {31'd0, o_sram_oe_n}, 32'd1);
    wait_ready();
    push(K_READ, 8'h9A);
    issue(16'h0100, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_ready();

    // Reset during the write pulse.
    push(K_ABORT, 8'h00);
    issue(16'h0200, 8'h11, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 10 && o_sram_we_n; n++) begin
      @(posedge clk); #1;
    end
    chk("abort_in_pulse", {31'd0, o_sram_we_n}, 32'd0);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    chk("abort_strobes", {29'd0, o_sram_we_n, o_sram_ce_n, o_sram_dq_oe}, 32'b110);
    chk("abort_ready", {31'd0, o_cpu_ready}, 32'd1);
    @(posedge clk); #1;

    // Recovery after reset.
    push(K_READ, 8'hAB);
    issue(16'h1235, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_ready();

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
